// File: rtl/pc_unit.sv
// pc_unit: program counter with reset vector, relative branch, absolute jump,
// call/return through a bounded hardware return-address stack, stall hold and
// sticky overflow/underflow error flags.
module pc_unit #(
   parameter int unsigned ADDR_WIDTH   = 6,
   parameter int unsigned OFFSET_WIDTH = 6,
   parameter int unsigned RESET_VECTOR = 0,
   parameter int unsigned STACK_DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    stall,
   input  logic [2:0]              op,
   input  logic                    taken,
   input  logic [OFFSET_WIDTH-1:0] offset,
   input  logic [ADDR_WIDTH-1:0]   target,
   input  logic                    err_clr,
   output logic [ADDR_WIDTH-1:0]   pc,
   output logic                    stack_empty,
   output logic                    stack_full,
   output logic                    overflow,
   output logic                    underflow
);

   // Count spans 0..STACK_DEPTH; index addresses the entry slots.
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << IDX_W;

   localparam logic [2:0] OP_SEQ    = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [CNT_W-1:0]      r_count;
   logic [ADDR_WIDTH-1:0] r_stack [SLOTS];
   logic                  r_overflow;
   logic                  r_underflow;

   logic [ADDR_WIDTH-1:0] w_pc_inc;
   logic [ADDR_WIDTH-1:0] w_off_ext;
   logic [ADDR_WIDTH-1:0] w_top;
   logic [IDX_W-1:0]      w_push_idx;
   logic [IDX_W-1:0]      w_top_idx;
   logic                  w_empty;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [CNT_W-1:0]      w_count_nxt;
   logic                  w_push;
   logic                  w_ovf_set;
   logic                  w_unf_set;

   // Datapath helpers: increment, sign-extended offset, stack top and push slot.
   assign w_pc_inc   = r_pc + ADDR_WIDTH'(1);
   assign w_off_ext  = ADDR_WIDTH'($signed(offset));
   assign w_push_idx = IDX_W'(r_count);
   assign w_top_idx  = IDX_W'(r_count - CNT_W'(1));
   assign w_top      = r_stack[w_top_idx];
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(STACK_DEPTH));

   // Next-PC selection and stack/error event decode; stall holds everything.
   always_comb begin
      w_pc_nxt    = r_pc;
      w_count_nxt = r_count;
      w_push      = 1'b0;
      w_ovf_set   = 1'b0;
      w_unf_set   = 1'b0;
      if (!stall) begin
         case (op)
            OP_BRANCH: w_pc_nxt = taken ? (r_pc + w_off_ext) : w_pc_inc;
            OP_JUMP:   w_pc_nxt = target;
            OP_CALL: begin
               w_pc_nxt = target;
               if (w_full) begin
                  w_ovf_set = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_count_nxt = r_count + CNT_W'(1);
               end
            end
            OP_RET: begin
               if (w_empty) begin
                  w_pc_nxt  = w_pc_inc;
                  w_unf_set = 1'b1;
               end else begin
                  w_pc_nxt    = w_top;
                  w_count_nxt = r_count - CNT_W'(1);
               end
            end
            default:   w_pc_nxt = w_pc_inc;
         endcase
      end
   end

   // Control registers: pc, stack count and sticky flags (set beats clear).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= ADDR_WIDTH'(RESET_VECTOR);
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_count     <= w_count_nxt;
         r_overflow  <= w_ovf_set | (r_overflow & ~err_clr);
         r_underflow <= w_unf_set | (r_underflow & ~err_clr);
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign pc          = r_pc;
   assign stack_empty = w_empty;
   assign stack_full  = w_full;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors for pc_unit; the driver queues hand-computed
// expectations and a negedge monitor pops and compares them.
module tb_pc_unit;

   localparam logic [2:0] SEQ = 3'b000;
   localparam logic [2:0] BRA = 3'b001;
   localparam logic [2:0] JMP = 3'b010;
   localparam logic [2:0] CAL = 3'b011;
   localparam logic [2:0] RET = 3'b100;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       stall = 1'b0;
   logic [2:0] op = 3'b000;
   logic       taken = 1'b0;
   logic [5:0] offset = '0;
   logic [5:0] target = '0;
   logic       err_clr = 1'b0;
   logic [5:0] pc;
   logic       stack_empty, stack_full, overflow, underflow;

   typedef struct {
      int         id;
      logic [5:0] pc;
      logic       e, f, o, u;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   vec_id   = 0;

   pc_unit #(
      .ADDR_WIDTH(6), .OFFSET_WIDTH(6), .RESET_VECTOR(0), .STACK_DEPTH(4)
   ) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .op(op), .taken(taken),
      .offset(offset), .target(target), .err_clr(err_clr), .pc(pc),
      .stack_empty(stack_empty), .stack_full(stack_full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [5:0] epc,
                          input logic ee, input logic ef, input logic eo, input logic eu);
      chk({tag, " pc"},          32'(pc),          32'(epc));
      chk({tag, " stack_empty"}, 32'(stack_empty), 32'(ee));
      chk({tag, " stack_full"},  32'(stack_full),  32'(ef));
      chk({tag, " overflow"},    32'(overflow),    32'(eo));
      chk({tag, " underflow"},   32'(underflow),   32'(eu));
   endtask

   // Drive one cycle of inputs, queue the expected post-edge state.
   task automatic step(input logic [2:0] o, input logic tk, input logic [5:0] off,
                       input logic [5:0] tg, input logic st, input logic ec,
                       input logic [5:0] epc, input logic ee, input logic ef,
                       input logic eo, input logic eu);
      exp_t e;
      op = o; taken = tk; offset = off; target = tg; stall = st; err_clr = ec;
      @(posedge clock);
      vec_id++;
      e.id = vec_id; e.pc = epc; e.e = ee; e.f = ef; e.o = eo; e.u = eu;
      q.push_back(e);
      @(negedge clock);
   endtask

   // Monitor: compare DUT state against each queued expectation.
   always @(negedge clock) begin
      if (q.size() > 0) begin
         m_e = q.pop_front();
         chk_all($sformatf("v%0d", m_e.id), m_e.pc, m_e.e, m_e.f, m_e.o, m_e.u);
      end
   end

   initial begin
      @(negedge clock);
      chk_all("reset", 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      //   op   tk off     tg     st ec  pc     E  F  O  U
      step(SEQ, 0, 6'd0,  6'd0,  0, 0, 6'd1,  1, 0, 0, 0);
      step(SEQ, 0, 6'd0,  6'd0,  0, 0, 6'd2,  1, 0, 0, 0);
      step(SEQ, 0, 6'd0,  6'd0,  0, 0, 6'd3,  1, 0, 0, 0);

      // asynchronous reset mid-cycle
      #2 reset_n = 1'b0;
      #1 chk_all("async_reset", 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;

      // branches and wrap
      step(JMP, 0, 6'd0,      6'd10, 0, 0, 6'd10, 1, 0, 0, 0);
      step(BRA, 1, 6'b111101, 6'd0,  0, 0, 6'd7,  1, 0, 0, 0);
      step(JMP, 0, 6'd0,      6'd10, 0, 0, 6'd10, 1, 0, 0, 0);
      step(BRA, 0, 6'b111101, 6'd0,  0, 0, 6'd11, 1, 0, 0, 0);
      step(JMP, 0, 6'd0,      6'd63, 0, 0, 6'd63, 1, 0, 0, 0);
      step(SEQ, 0, 6'd0,      6'd0,  0, 0, 6'd0,  1, 0, 0, 0);
      step(JMP, 0, 6'd0,      6'd62, 0, 0, 6'd62, 1, 0, 0, 0);
      step(BRA, 1, 6'd5,      6'd0,  0, 0, 6'd3,  1, 0, 0, 0);
      step(3'b111, 1, 6'd5,   6'd40, 0, 0, 6'd4,  1, 0, 0, 0);

      // nested call/return
      step(JMP, 0, 6'd0, 6'd5,  0, 0, 6'd5,  1, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd20, 0, 0, 6'd20, 0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd40, 0, 0, 6'd40, 0, 0, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd21, 0, 0, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd6,  1, 0, 0, 0);

      // fill, overflow, LIFO drain
      step(CAL, 0, 6'd0, 6'd1,  0, 0, 6'd1,  0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd2,  0, 0, 6'd2,  0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd3,  0, 0, 6'd3,  0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd4,  0, 0, 6'd4,  0, 1, 0, 0);
      step(CAL, 0, 6'd0, 6'd50, 0, 0, 6'd50, 0, 1, 1, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd4,  0, 0, 1, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd3,  0, 0, 1, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd2,  0, 0, 1, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd7,  1, 0, 1, 0);
      step(SEQ, 0, 6'd0, 6'd0,  0, 1, 6'd8,  1, 0, 0, 0);

      // underflow and err_clr interplay
      step(JMP, 0, 6'd0, 6'd9,  0, 0, 6'd9,  1, 0, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd10, 1, 0, 0, 1);
      step(SEQ, 0, 6'd0, 6'd0,  0, 0, 6'd11, 1, 0, 0, 1);
      step(SEQ, 0, 6'd0, 6'd0,  0, 0, 6'd12, 1, 0, 0, 1);
      step(SEQ, 0, 6'd0, 6'd0,  0, 1, 6'd13, 1, 0, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 1, 6'd14, 1, 0, 0, 1);
      step(SEQ, 0, 6'd0, 6'd0,  0, 1, 6'd15, 1, 0, 0, 0);

      // refill, overflow coincident with err_clr
      step(CAL, 0, 6'd0, 6'd20, 0, 0, 6'd20, 0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd21, 0, 0, 6'd21, 0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd22, 0, 0, 6'd22, 0, 0, 0, 0);
      step(CAL, 0, 6'd0, 6'd23, 0, 0, 6'd23, 0, 1, 0, 0);
      step(CAL, 0, 6'd0, 6'd30, 0, 1, 6'd30, 0, 1, 1, 0);

      // stall holds pc and stack; err_clr still acts
      step(JMP, 0, 6'd0, 6'd33, 1, 0, 6'd30, 0, 1, 1, 0);
      step(JMP, 0, 6'd0, 6'd33, 1, 0, 6'd30, 0, 1, 1, 0);
      step(RET, 0, 6'd0, 6'd33, 1, 0, 6'd30, 0, 1, 1, 0);
      step(JMP, 0, 6'd0, 6'd33, 1, 1, 6'd30, 0, 1, 0, 0);
      step(JMP, 0, 6'd0, 6'd33, 0, 0, 6'd33, 0, 1, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd23, 0, 0, 0, 0);
      step(RET, 0, 6'd0, 6'd0,  0, 0, 6'd22, 0, 0, 0, 0);

      op = SEQ; stall = 1'b0; err_clr = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
